regfile_write_arbiter: RTL and testbench

//  Shares the single write port (d_in, per-register en) of the 23 x 64-bit register bank

---
 rtl/regfile_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/regfile_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants, FSM state encoding and a clog2 helper for
//                the register-bank write arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int NUM_REG = 23;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 5;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Grants the first asserted
//                request at or after ptr, wrapping modulo NUM_REQ.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic found;
    int   cand;

    // Scan requesters starting at ptr; the first one found wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Round-robin arbitration of NUM_REQ writers onto the single
//                write port of the register bank, plus a bulk-clear sequencer
//                that zeroes every register, one per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int NUM_REG = regfile_pkg::NUM_REG,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        clr_start,
    output logic                        clr_busy,
    output logic                        clr_done,
    output logic [NUM_REG-1:0]          en,
    output logic [DATA_W-1:0]           d_in,
    output logic                        err_addr,
    output logic [clog2(NUM_REQ)-1:0]   err_id
);

    localparam int ID_W = clog2(NUM_REQ);

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   cnt_q,      cnt_d;
    logic [ID_W-1:0]     rr_ptr_q,   rr_ptr_d;
    logic [NUM_REG-1:0]  en_q,       en_d;
    logic [DATA_W-1:0]   d_in_q,     d_in_d;
    logic                clr_busy_q, clr_busy_d;
    logic                clr_done_q, clr_done_d;
    logic                err_addr_q, err_addr_d;
    logic [ID_W-1:0]     err_id_q,   err_id_d;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_open;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Grants are only offered in ARB, outside reset, and when no clear is requested
    assign arb_open  = reset_n && (state_q == ST_ARB) && !clr_start;
    assign req_ready = arb_open ? arb_gnt : '0;

    // Route the granted requester's address and data
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and output-register logic for the ARB/CLEAR sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        en_d       = '0;
        d_in_d     = d_in_q;
        clr_busy_d = clr_busy_q;
        clr_done_d = 1'b0;
        err_addr_d = 1'b0;
        err_id_d   = err_id_q;
        case (state_q)
            ST_ARB: begin
                if (clr_start) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = '0;
                    clr_busy_d = 1'b1;
                end else if (|arb_gnt) begin
                    rr_ptr_d = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
                    // Out-of-range addresses are consumed but never reach the bank
                    if ({1'b0, sel_addr} < (ADDR_W + 1)'(NUM_REG)) begin
                        en_d   = NUM_REG'(1) << sel_addr;
                        d_in_d = sel_data;
                    end else begin
                        err_addr_d = 1'b1;
                        err_id_d   = arb_idx;
                    end
                end
            end
            ST_CLEAR: begin
                en_d   = NUM_REG'(1) << cnt_q;
                d_in_d = '0;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(NUM_REG - 1)) begin
                    state_d    = ST_ARB;
                    clr_done_d = 1'b1;
                    clr_busy_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ARB;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            en_q       <= '0;
            d_in_q     <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            err_addr_q <= 1'b0;
            err_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            en_q       <= en_d;
            d_in_q     <= d_in_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            err_addr_q <= err_addr_d;
            err_id_q   <= err_id_d;
        end
    end

    assign en       = en_q;
    assign d_in     = d_in_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;
    assign err_addr = err_addr_q;
    assign err_id   = err_id_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Directed self-checking bench for regfile_write_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int NUM_REG = 23;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 5;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      clr_start;
    logic                      clr_busy;
    logic                      clr_done;
    logic [NUM_REG-1:0]        en;
    logic [DATA_W-1:0]         d_in;
    logic                      err_addr;
    logic [1:0]                err_id;

    int checks   = 0;
    int failures = 0;
    int cycles;

    regfile_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_REG (NUM_REG),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .en        (en),
        .d_in      (d_in),
        .err_addr  (err_addr),
        .err_id    (err_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[i]               = v;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    function automatic logic [63:0] oh(input int k);
        logic [63:0] one;
        one = 64'd1;
        return one << k;
    endfunction

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'b0001;
        req_addr  = '0;
        req_data  = '0;
        clr_start = 1'b0;
        #2;
        check_eq("rst_en",       64'(en),        64'd0);
        check_eq("rst_d_in",     d_in,           64'd0);
        check_eq("rst_busy",     64'(clr_busy),  64'd0);
        check_eq("rst_done",     64'(clr_done),  64'd0);
        check_eq("rst_err",      64'(err_addr),  64'd0);
        check_eq("rst_err_id",   64'(err_id),    64'd0);
        check_eq("rst_ready",    64'(req_ready), 64'd0);
        step();
        step();
        reset_n   = 1'b1;
        req_valid = '0;

        // Single write from requester 0
        set_req(0, 1'b1, 5'd5, 64'hA5);
        #1 check_eq("t1_ready", 64'(req_ready), 64'b0001);
        step();
        check_eq("t1_en",   64'(en), oh(5));
        check_eq("t1_d_in", d_in,    64'hA5);
        req_valid = '0;
        #1 check_eq("t1_idle_ready", 64'(req_ready), 64'd0);
        step();
        check_eq("t1_idle_en",   64'(en), 64'd0);
        check_eq("t1_hold_d_in", d_in,    64'hA5);

        // Fresh reset so the pointer restarts at 0
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;

        // Four requesters held valid: grants 0,1,2,3 then wrap to 0
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, ADDR_W'(10 + i), 64'(256 + i));
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % NUM_REQ;
            #1 check_eq("t2_ready", 64'(req_ready), oh(e));
            step();
            check_eq("t2_en",   64'(en), oh(10 + e));
            check_eq("t2_d_in", d_in,    64'(256 + e));
        end
        req_valid = '0;
        step();
        check_eq("t2_idle_en", 64'(en), 64'd0);

        // Out-of-range addresses (pointer is now 1)
        set_req(1, 1'b1, 5'd23, 64'hDEAD);
        #1 check_eq("t3_ready23", 64'(req_ready), 64'b0010);
        step();
        check_eq("t3_en23",  64'(en),       64'd0);
        check_eq("t3_err23", 64'(err_addr), 64'd1);
        check_eq("t3_id23",  64'(err_id),   64'd1);
        set_req(1, 1'b1, 5'd31, 64'hBEEF);
        #1 check_eq("t3_ready31", 64'(req_ready), 64'b0010);
        step();
        check_eq("t3_en31",  64'(en),       64'd0);
        check_eq("t3_err31", 64'(err_addr), 64'd1);
        check_eq("t3_id31",  64'(err_id),   64'd1);
        req_valid = '0;
        set_req(3, 1'b1, 5'd24, 64'h1);
        #1 check_eq("t3_ready24", 64'(req_ready), 64'b1000);
        step();
        check_eq("t3_err24", 64'(err_addr), 64'd1);
        check_eq("t3_id24",  64'(err_id),   64'd3);
        req_valid = '0;
        step();
        check_eq("t3_err_fall", 64'(err_addr), 64'd0);
        check_eq("t3_id_hold",  64'(err_id),   64'd3);
        check_eq("t3_en_idle",  64'(en),       64'd0);

        // Bulk clear with requester 0 waiting
        set_req(0, 1'b1, 5'd7, 64'h77);
        clr_start = 1'b1;
        #1 check_eq("t4_ready_blocked", 64'(req_ready), 64'd0);
        step();
        clr_start = 1'b0;
        check_eq("t4_busy_enter", 64'(clr_busy), 64'd1);
        check_eq("t4_en_enter",   64'(en),       64'd0);
        check_eq("t4_ready_clr",  64'(req_ready), 64'd0);
        for (int k = 0; k < NUM_REG; k++) begin
            step();
            check_eq("t4_en_walk",   64'(en), oh(k));
            check_eq("t4_d_in_zero", d_in,    64'd0);
            if (k < NUM_REG - 1) begin
                check_eq("t4_busy",  64'(clr_busy),  64'd1);
                check_eq("t4_done",  64'(clr_done),  64'd0);
                check_eq("t4_ready", 64'(req_ready), 64'd0);
            end else begin
                check_eq("t4_busy_end",  64'(clr_busy),  64'd0);
                check_eq("t4_done_end",  64'(clr_done),  64'd1);
                check_eq("t4_ready_end", 64'(req_ready), 64'b0001);
            end
        end
        step();
        check_eq("t4_post_en",   64'(en),       64'(oh(7)));
        check_eq("t4_post_d_in", d_in,          64'h77);
        check_eq("t4_post_done", 64'(clr_done), 64'd0);
        req_valid = '0;

        // Reset in the middle of a clear
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        set_req(0, 1'b1, 5'd3, 64'h33);
        for (int k = 0; k < 10; k++) step();
        check_eq("t5_en_mid", 64'(en), oh(9));
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5_rst_en",    64'(en),        64'd0);
        check_eq("t5_rst_d_in",  d_in,           64'd0);
        check_eq("t5_rst_busy",  64'(clr_busy),  64'd0);
        check_eq("t5_rst_ready", 64'(req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("t5_no_done", 64'(clr_done), 64'd0);
        end
        reset_n = 1'b1;
        #1 check_eq("t5_ready_after", 64'(req_ready), 64'b0001);
        step();
        check_eq("t5_en_after",   64'(en), oh(3));
        check_eq("t5_d_in_after", d_in,    64'h33);
        check_eq("t5_done_after", 64'(clr_done), 64'd0);
        req_valid = '0;
        step();

        // clr_start re-pulsed during CLEAR does not extend the sequence
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        cycles = 0;
        while (cycles < 40 && !clr_done) begin
            clr_start = (cycles == 3);
            step();
            cycles++;
        end
        clr_start = 1'b0;
        check_eq("t6_len",  64'(cycles),   64'd23);
        check_eq("t6_busy", 64'(clr_busy), 64'd0);
        step();
        check_eq("t6_done_pulse", 64'(clr_done), 64'd0);
        check_eq("t6_no_restart", 64'(clr_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
